// File: rtl/bsg_manycore_out_arb_pkg.sv
// Shared types and helpers for the manycore endpoint outgoing-packet arbiter.
//   state_e       : fence FSM encoding (run / drain / done)
//   avail_credits : endpoint credits left after the buffered packet is committed
package bsg_manycore_out_arb_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StDone  = 2'd2
  } state_e;

  // A buffered packet already owns one credit, even while it is launching, because the
  // endpoint only decrements its counter the cycle after the launch. Never goes negative.
  function automatic int unsigned avail_credits(input int unsigned credits, input logic buf_v);
    if (!buf_v) begin
      return credits;
    end else if (credits == 0) begin
      return 0;
    end else begin
      return credits - 1;
    end
  endfunction

endpackage

// File: rtl/bsg_manycore_out_arb_rr.sv
// Round-robin pick: first eligible requester at or after the pointer, modulo num_req_p.
// Ports:
//   ptr_i      : current round-robin pointer
//   elig_i     : per-requester eligibility
//   v_o        : at least one requester is eligible
//   grant_oh_o : one-hot winner (zero when v_o is low)
//   id_o       : winner index
//   next_ptr_o : winner + 1, wrapping to 0 after num_req_p-1
module bsg_manycore_out_arb_rr #(
  parameter int unsigned num_req_p  = 2,
  parameter int unsigned id_width_p = 1
) (
  input  logic [id_width_p-1:0] ptr_i,
  input  logic [num_req_p-1:0]  elig_i,
  output logic                  v_o,
  output logic [num_req_p-1:0]  grant_oh_o,
  output logic [id_width_p-1:0] id_o,
  output logic [id_width_p-1:0] next_ptr_o
);

  always_comb begin
    int idx;
    v_o        = 1'b0;
    id_o       = '0;
    grant_oh_o = '0;
    idx        = 0;
    // Walk from the farthest offset down so the nearest eligible index wins.
    for (int k = int'(num_req_p) - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= int'(num_req_p)) idx = idx - int'(num_req_p);
      if (elig_i[idx]) begin
        v_o             = 1'b1;
        id_o            = id_width_p'(idx);
        grant_oh_o      = '0;
        grant_oh_o[idx] = 1'b1;
      end
    end
    next_ptr_o = (id_o == id_width_p'(num_req_p - 1)) ? '0 : id_o + id_width_p'(1);
  end

endmodule

// File: rtl/bsg_manycore_endpoint_out_arb.sv
// Credit-aware scheduler sharing one manycore endpoint's outgoing packet port among
// num_req_p requesters through a one-entry output buffer. The last reserve_credits_p
// credits are usable only by requester 0. A level fence drains the buffer and waits for
// every credit to return, then pulses fence_done_o.
// Ports:
//   clk_i, reset_i         : clock, synchronous active-high reset
//   req_v_i / req_packet_i : per-requester valid and packet slices
//   req_yumi_o             : one-hot dequeue in the cycle the buffer loads
//   out_v_o / out_packet_o : buffered packet toward the endpoint
//   out_ready_i            : endpoint ready
//   out_credits_i          : endpoint credit count
//   out_id_o               : requester index of the buffered packet
//   fence_i / fence_done_o : fence request (level) and completion pulse
//   stall_cycles_o         : saturating stall counter
// Optional: define BSG_MANYCORE_OUT_ARB_STATS_EN to build the stall counter; otherwise
// stall_cycles_o is tied to zero.
module bsg_manycore_endpoint_out_arb
  import bsg_manycore_out_arb_pkg::*;
#(
  parameter int unsigned num_req_p         = 2,
  parameter int unsigned packet_width_p    = 32,
  parameter int unsigned max_out_credits_p = 16,
  parameter int unsigned reserve_credits_p = 1,
  localparam int unsigned credit_width_lp  = $clog2(max_out_credits_p + 1),
  localparam int unsigned id_width_lp      = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_req_p-1:0]                req_v_i,
  input  logic [num_req_p*packet_width_p-1:0] req_packet_i,
  output logic [num_req_p-1:0]                req_yumi_o,
  output logic                                out_v_o,
  output logic [packet_width_p-1:0]           out_packet_o,
  input  logic                                out_ready_i,
  input  logic [credit_width_lp-1:0]          out_credits_i,
  output logic [id_width_lp-1:0]              out_id_o,
  input  logic                                fence_i,
  output logic                                fence_done_o,
  output logic [31:0]                         stall_cycles_o
);

  logic                      buf_v_q, buf_v_d;
  logic [packet_width_p-1:0] packet_q, packet_d;
  logic [id_width_lp-1:0]    id_q, id_d;
  logic [id_width_lp-1:0]    ptr_q, ptr_d;
  state_e                    state_q, state_d;

  int unsigned               avail;
  logic                      launch, free, grant;
  logic [num_req_p-1:0]      elig;
  logic                      rr_v;
  logic [num_req_p-1:0]      rr_oh;
  logic [id_width_lp-1:0]    rr_id, rr_next_ptr;
  logic [packet_width_p-1:0] sel_packet;

  assign launch = buf_v_q & out_ready_i;
  assign free   = ~buf_v_q | launch;
  assign avail  = avail_credits(32'(out_credits_i), buf_v_q);

  always_comb begin
    elig    = '0;
    elig[0] = req_v_i[0] && (avail >= 1);
    for (int i = 1; i < int'(num_req_p); i++) begin
      elig[i] = req_v_i[i] && (avail > reserve_credits_p);
    end
  end

  bsg_manycore_out_arb_rr #(
    .num_req_p  (num_req_p),
    .id_width_p (id_width_lp)
  ) u_rr (
    .ptr_i      (ptr_q),
    .elig_i     (elig),
    .v_o        (rr_v),
    .grant_oh_o (rr_oh),
    .id_o       (rr_id),
    .next_ptr_o (rr_next_ptr)
  );

  // Arbitration ignores fence_i, so a grant coinciding with the fence edge still completes.
  assign grant      = (state_q == StRun) && free && rr_v;
  assign req_yumi_o = grant ? rr_oh : '0;

  always_comb begin
    sel_packet = '0;
    for (int i = 0; i < int'(num_req_p); i++) begin
      if (rr_id == id_width_lp'(i)) sel_packet = req_packet_i[i*packet_width_p +: packet_width_p];
    end
  end

  always_comb begin
    buf_v_d  = buf_v_q;
    packet_d = packet_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    if (grant) begin
      buf_v_d  = 1'b1;
      packet_d = sel_packet;
      id_d     = rr_id;
      ptr_d    = rr_next_ptr;
    end else if (launch) begin
      buf_v_d = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    fence_done_o = 1'b0;
    unique case (state_q)
      StRun: begin
        if (fence_i) state_d = StDrain;
      end
      StDrain: begin
        if (!buf_v_q && (out_credits_i == credit_width_lp'(max_out_credits_p))) state_d = StDone;
      end
      StDone: begin
        fence_done_o = 1'b1;
        state_d      = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      buf_v_q  <= 1'b0;
      packet_q <= '0;
      id_q     <= '0;
      ptr_q    <= '0;
      state_q  <= StRun;
    end else begin
      buf_v_q  <= buf_v_d;
      packet_q <= packet_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
      state_q  <= state_d;
    end
  end

  assign out_v_o      = buf_v_q;
  assign out_packet_o = packet_q;
  assign out_id_o     = id_q;

`ifdef BSG_MANYCORE_OUT_ARB_STATS_EN
  logic [31:0] stall_q, stall_d;

  // Fence-induced idling is intentional and not counted as a stall.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == StRun) && (|req_v_i) && !grant && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_bsg_manycore_endpoint_out_arb.sv
module tb_bsg_manycore_endpoint_out_arb;

  localparam int N   = 3;
  localparam int W   = 8;
  localparam int MAX = 4;
  localparam int RES = 1;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [N-1:0] req_v_i;
  logic [N*W-1:0] req_packet_i;
  logic [N-1:0] req_yumi_o;
  logic         out_v_o;
  logic [W-1:0] out_packet_o;
  logic         out_ready_i;
  logic [2:0]   out_credits_i;
  logic [1:0]   out_id_o;
  logic         fence_i;
  logic         fence_done_o;
  logic [31:0]  stall_cycles_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  bsg_manycore_endpoint_out_arb #(
    .num_req_p         (N),
    .packet_width_p    (W),
    .max_out_credits_p (MAX),
    .reserve_credits_p (RES)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .req_v_i        (req_v_i),
    .req_packet_i   (req_packet_i),
    .req_yumi_o     (req_yumi_o),
    .out_v_o        (out_v_o),
    .out_packet_o   (out_packet_o),
    .out_ready_i    (out_ready_i),
    .out_credits_i  (out_credits_i),
    .out_id_o       (out_id_o),
    .fence_i        (fence_i),
    .fence_done_o   (fence_done_o),
    .stall_cycles_o (stall_cycles_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] req_v;
    logic       ready;
    logic [2:0] cred;
    logic [2:0] exp_yumi;
    logic       exp_v;
    logic [1:0] exp_id;
  } vec_t;

  vec_t vecs[11];

  // Reference model state
  int          m_buf_v, m_id, m_ptr, m_state;
  logic [W-1:0] m_pkt;
  logic [31:0] m_stall;
  int          cred;
  int          fences_done;

  task automatic do_reset();
    reset_i = 1'b1;
    @(posedge clk_i); @(posedge clk_i); #1;
    reset_i = 1'b0;
    m_buf_v = 0; m_id = 0; m_ptr = 0; m_state = 0; m_pkt = '0; m_stall = '0;
  endtask

  initial begin
    logic [W-1:0] exp_pkt;
    reset_i = 1'b1; req_v_i = '0; req_packet_i = '0; out_ready_i = 1'b0;
    out_credits_i = 3'd4; fence_i = 1'b0;

    // credits follow what the endpoint would show; reserve blocks req1/2 at avail<=1
    vecs[0]  = '{3'b111, 1'b1, 3'd4, 3'b001, 1'b0, 2'd0};
    vecs[1]  = '{3'b111, 1'b1, 3'd4, 3'b010, 1'b1, 2'd0};
    vecs[2]  = '{3'b111, 1'b1, 3'd3, 3'b100, 1'b1, 2'd1};
    vecs[3]  = '{3'b111, 1'b1, 3'd2, 3'b001, 1'b1, 2'd2};
    vecs[4]  = '{3'b111, 1'b1, 3'd1, 3'b000, 1'b1, 2'd0};
    vecs[5]  = '{3'b111, 1'b1, 3'd0, 3'b000, 1'b0, 2'd0};
    vecs[6]  = '{3'b111, 1'b1, 3'd2, 3'b010, 1'b0, 2'd0};
    vecs[7]  = '{3'b111, 1'b0, 3'd2, 3'b000, 1'b1, 2'd1};
    vecs[8]  = '{3'b111, 1'b0, 3'd2, 3'b000, 1'b1, 2'd1};
    vecs[9]  = '{3'b111, 1'b1, 3'd2, 3'b001, 1'b1, 2'd1};
    vecs[10] = '{3'b111, 1'b1, 3'd1, 3'b000, 1'b1, 2'd0};

    do_reset();
    req_packet_i = {8'hA2, 8'hA1, 8'hA0};
    @(negedge clk_i);
    check("reset_out_v", 32'(out_v_o), 32'd0);
    check("reset_out_id", 32'(out_id_o), 32'd0);
    check("reset_out_packet", 32'(out_packet_o), 32'd0);
    check("reset_fence_done", 32'(fence_done_o), 32'd0);
    check("reset_stall", stall_cycles_o, 32'd0);
    @(posedge clk_i); #1;
    do_reset();

    for (int i = 0; i < 11; i++) begin
      req_v_i = vecs[i].req_v;
      out_ready_i = vecs[i].ready;
      out_credits_i = vecs[i].cred;
      @(negedge clk_i);
      check($sformatf("vec%0d_yumi", i), 32'(req_yumi_o), 32'(vecs[i].exp_yumi));
      check($sformatf("vec%0d_out_v", i), 32'(out_v_o), 32'(vecs[i].exp_v));
      if (vecs[i].exp_v) begin
        exp_pkt = 8'hA0 + {6'd0, vecs[i].exp_id};
        check($sformatf("vec%0d_id", i), 32'(out_id_o), 32'(vecs[i].exp_id));
        check($sformatf("vec%0d_packet", i), 32'(out_packet_o), 32'(exp_pkt));
      end
      @(posedge clk_i); #1;
    end

    // Reset while a packet is buffered: packet dropped, pointer back to 0.
    req_v_i = 3'b010; out_ready_i = 1'b0; out_credits_i = 3'd4;
    @(negedge clk_i);
    check("rst_seq_yumi", 32'(req_yumi_o), 32'b010);
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    @(negedge clk_i);
    check("rst_seq_buffered", 32'(out_v_o), 32'd1);
    @(posedge clk_i); #1;
    reset_i = 1'b0; req_v_i = 3'b111; out_ready_i = 1'b1;
    @(negedge clk_i);
    check("rst_seq_out_v", 32'(out_v_o), 32'd0);
    check("rst_seq_id", 32'(out_id_o), 32'd0);
    check("rst_seq_ptr0_yumi", 32'(req_yumi_o), 32'b001);
    check("rst_seq_stall", stall_cycles_o, 32'd0);
    @(posedge clk_i); #1;

    // Randomized phase against a behavioural model with an endpoint credit model.
    req_v_i = '0; out_ready_i = 1'b0; fence_i = 1'b0;
    cred = MAX; out_credits_i = 3'(MAX);
    do_reset();
    fences_done = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int avail, win, launch, grant, ret;
      int n_buf, n_id, n_ptr, n_state;
      logic [W-1:0] n_pkt;
      logic [31:0] n_stall;
      logic [N-1:0] exp_yumi;
      req_v_i = 3'($urandom);
      req_packet_i = 24'($urandom);
      out_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk_i);
      launch = m_buf_v && out_ready_i;
      avail = (cred > m_buf_v) ? cred - m_buf_v : 0;
      win = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (win < 0 && req_v_i[j] && ((j == 0) ? (avail >= 1) : (avail > RES))) win = j;
      end
      grant = (m_state == 0) && (!m_buf_v || launch) && (win >= 0);
      exp_yumi = grant ? 3'(1 << win) : 3'b000;
      check("rnd_yumi", 32'(req_yumi_o), 32'(exp_yumi));
      check("rnd_out_v", 32'(out_v_o), 32'(m_buf_v));
      if (m_buf_v != 0) begin
        check("rnd_id", 32'(out_id_o), 32'(m_id));
        check("rnd_packet", 32'(out_packet_o), 32'(m_pkt));
      end
      check("rnd_fence_done", 32'(fence_done_o), 32'(m_state == 2));
`ifdef BSG_MANYCORE_OUT_ARB_STATS_EN
      check("rnd_stall", stall_cycles_o, m_stall);
`else
      check("rnd_stall", stall_cycles_o, 32'd0);
`endif
      n_buf = m_buf_v; n_id = m_id; n_ptr = m_ptr; n_pkt = m_pkt; n_stall = m_stall;
      if (grant) begin
        n_buf = 1; n_id = win; n_ptr = (win + 1) % N; n_pkt = req_packet_i[win*W +: W];
      end else if (launch) begin
        n_buf = 0;
      end
      case (m_state)
        0: n_state = fence_i ? 1 : 0;
        1: n_state = (m_buf_v == 0 && cred == MAX) ? 2 : 1;
        default: n_state = 0;
      endcase
      if (m_state == 0 && req_v_i != 0 && !grant && m_stall != 32'hFFFF_FFFF) n_stall = m_stall + 1;
      ret = (cred < MAX && $urandom_range(0, 1) == 1) ? $urandom_range(1, MAX - cred) : 0;
      @(posedge clk_i); #1;
      if (m_state == 2) begin
        fence_i = 1'b0;
        fences_done++;
      end else if (!fence_i && $urandom_range(0, 24) == 0) begin
        fence_i = 1'b1;
      end
      m_buf_v = n_buf; m_id = n_id; m_ptr = n_ptr; m_pkt = n_pkt; m_state = n_state;
      m_stall = n_stall;
      cred = cred - launch + ret;
      out_credits_i = 3'(cred);
    end
    check("fences_completed", 32'(fences_done > 0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
